// File: rtl/mem_arb_pkg.sv
// -----------------------------------------------------------------------------
// mem_arb_pkg
// Shared definitions for the unified-memory arbiter between the ARM core and
// the debug requester: owner encoding for visualization and default bus widths.
// -----------------------------------------------------------------------------
package mem_arb_pkg;

  localparam int AW_DEF = 32;
  localparam int DW_DEF = 32;

  typedef enum logic [1:0] {
    OWN_NONE = 2'b00,
    OWN_CPU  = 2'b01,
    OWN_DBG  = 2'b10
  } owner_e;

endpackage

// File: rtl/mem_arb_wait_ctr.sv
// -----------------------------------------------------------------------------
// mem_arb_wait_ctr
// Saturating starvation counter for the debug port. Counts consecutive cycles
// in which the debug request was denied; at_max tells the arbiter to force a
// debug grant.
//
// Ports:
//   clk     in   system clock
//   reset   in   asynchronous active-low reset
//   inc     in   debug request denied this cycle
//   clr     in   debug granted or not requesting (takes precedence over inc)
//   at_max  out  count has reached DBG_MAX_WAIT
// -----------------------------------------------------------------------------
module mem_arb_wait_ctr
  import mem_arb_pkg::*;
#(
  parameter int DBG_MAX_WAIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic at_max
);

  // A limit of 0 still needs a 1-bit register; it simply never leaves 0.
  localparam int CW = (DBG_MAX_WAIT > 0) ? $clog2(DBG_MAX_WAIT + 1) : 1;
  localparam logic [CW-1:0] MAX_CNT = CW'(DBG_MAX_WAIT);

  logic [CW-1:0] cnt_q, cnt_d;

  assign at_max = (cnt_q == MAX_CNT);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && !at_max) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Shares the single unified instruction/data memory between the multicycle ARM
// core (fixed priority) and a debug requester. A bounded-wait counter forces a
// debug grant after DBG_MAX_WAIT consecutive denials so debug always progresses.
// Grants are combinational; read data returns registered one cycle later.
//
// Configuration macro: MEM_ARB_DBG_WRITE_EN
//   defined     - dbg_we reaches the memory (debug can load memory)
//   not defined - debug writes complete the handshake but never drive mem_we
//
// Ports:
//   clk, reset                      clock, asynchronous active-low reset
//   cpu_req/we/adr/wd  -> cpu_gnt   core request; grant = access at this edge
//   cpu_rvalid/cpu_rdata            registered core read return
//   dbg_req/we/adr/wd  -> dbg_gnt   debug request; grant = access at this edge
//   dbg_rvalid/dbg_rdata            registered debug read return
//   mem_we/mem_a/mem_wd, mem_rd     memory port (combinational read)
//   owner                           current grant owner (NONE/CPU/DBG)
// -----------------------------------------------------------------------------
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW           = AW_DEF,
  parameter int DW           = DW_DEF,
  parameter int DBG_MAX_WAIT = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_adr,
  input  logic [DW-1:0] cpu_wd,
  output logic          cpu_gnt,
  output logic          cpu_rvalid,
  output logic [DW-1:0] cpu_rdata,
  input  logic          dbg_req,
  input  logic          dbg_we,
  input  logic [AW-1:0] dbg_adr,
  input  logic [DW-1:0] dbg_wd,
  output logic          dbg_gnt,
  output logic          dbg_rvalid,
  output logic [DW-1:0] dbg_rdata,
  output logic          mem_we,
  output logic [AW-1:0] mem_a,
  output logic [DW-1:0] mem_wd,
  input  logic [DW-1:0] mem_rd,
  output logic [1:0]    owner
);

  logic dbg_at_max;
  logic dbg_we_eff;

  logic          cpu_rvalid_q, cpu_rvalid_d;
  logic [DW-1:0] cpu_rdata_q,  cpu_rdata_d;
  logic          dbg_rvalid_q, dbg_rvalid_d;
  logic [DW-1:0] dbg_rdata_q,  dbg_rdata_d;

  mem_arb_wait_ctr #(
    .DBG_MAX_WAIT(DBG_MAX_WAIT)
  ) u_wait_ctr (
    .clk   (clk),
    .reset (reset),
    .inc   (dbg_req & ~dbg_gnt),
    .clr   (dbg_gnt | ~dbg_req),
    .at_max(dbg_at_max)
  );

`ifdef MEM_ARB_DBG_WRITE_EN
  assign dbg_we_eff = dbg_we;
`else
  assign dbg_we_eff = 1'b0;
`endif

  // Grants and memory mux. Reset gates the grants combinationally so that no
  // write can reach memory at any edge while reset is held.
  always_comb begin
    dbg_gnt = 1'b0;
    cpu_gnt = 1'b0;
    owner   = OWN_NONE;
    mem_a   = cpu_adr;
    mem_wd  = cpu_wd;
    mem_we  = 1'b0;
    if (reset) begin
      if (dbg_req && (dbg_at_max || !cpu_req)) begin
        dbg_gnt = 1'b1;
        owner   = OWN_DBG;
        mem_a   = dbg_adr;
        mem_wd  = dbg_wd;
        mem_we  = dbg_we_eff;
      end else if (cpu_req) begin
        cpu_gnt = 1'b1;
        owner   = OWN_CPU;
        mem_we  = cpu_we;
      end
    end
  end

  // Read return: capture at the grant edge of a read, pulse rvalid for one
  // cycle; rdata holds across writes and idle cycles.
  always_comb begin
    cpu_rvalid_d = cpu_gnt & ~cpu_we;
    cpu_rdata_d  = cpu_rvalid_d ? mem_rd : cpu_rdata_q;
    dbg_rvalid_d = dbg_gnt & ~dbg_we;
    dbg_rdata_d  = dbg_rvalid_d ? mem_rd : dbg_rdata_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cpu_rvalid_q <= 1'b0;
      cpu_rdata_q  <= '0;
      dbg_rvalid_q <= 1'b0;
      dbg_rdata_q  <= '0;
    end else begin
      cpu_rvalid_q <= cpu_rvalid_d;
      cpu_rdata_q  <= cpu_rdata_d;
      dbg_rvalid_q <= dbg_rvalid_d;
      dbg_rdata_q  <= dbg_rdata_d;
    end
  end

  assign cpu_rvalid = cpu_rvalid_q;
  assign cpu_rdata  = cpu_rdata_q;
  assign dbg_rvalid = dbg_rvalid_q;
  assign dbg_rdata  = dbg_rdata_q;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares the single unified instruction/data memory between the multicycle ARM core and a debug requester, such as a display/readback engine or a host loader. The core has fixed priority, and a bounded-wait counter guarantees the debug port progress. The arbiter sits between `arm` and `mem` in `top`. Each requester sees a request/grant handshake and a registered read-data return.

## Interface
- `AW`, 32, address width
- `DW`, 32, data width
- `DBG_MAX_WAIT`, 4, max consecutive cycles `dbg_req` may be denied before a forced debug grant (0 = debug always wins)

- `clk`  in  1  system clock
- `reset`  in  1  asynchronous, active-low reset (0 = reset asserted)
- `cpu_req` / `cpu_we`  in  1  core access request / write enable
- `cpu_adr`  in  AW  core byte address
- `cpu_wd`  in  DW  core write data
- `cpu_gnt`  out  1  core access performed at this clock edge
- `cpu_rvalid`  out  1  `cpu_rdata` valid (one-cycle pulse)
- `cpu_rdata`  out  DW  registered core read data
- `dbg_req` / `dbg_we`  in  1  debug request / write enable
- `dbg_adr`  in  AW  debug address
- `dbg_wd`  in  DW  debug write data
- `dbg_gnt`  out  1  debug access performed at this edge
- `dbg_rvalid`  out  1  `dbg_rdata` valid (one-cycle pulse)
- `dbg_rdata`  out  DW  registered debug read data
- `mem_we`  out  1  to `mem.we`
- `mem_a`  out  AW  to `mem.a`
- `mem_wd`  out  DW  to `mem.wd`
- `mem_rd`  in  DW  from `mem.rd` (combinational read)
- `owner`  out  2  current-cycle grant owner, for visualization

## Operation
- Requests are level signals. `*_adr`, `*_we` and `*_wd` must stay stable while `*_req`=1 and `*_gnt`=0.
- Grants are combinational from `*_req`, `wait_cnt` and reset. At most one grant is active per cycle.
- Arbitration:
  - If `dbg_req` and `wait_cnt`==`DBG_MAX_WAIT`, debug wins.
  - Otherwise, if `cpu_req`, the core wins.
  - Otherwise, if `dbg_req`, debug wins.
- `wait_cnt`:
  - increments when `dbg_req`=1 and `dbg_gnt`=0, saturating at `DBG_MAX_WAIT`
  - clears when `dbg_gnt`=1 or `dbg_req`=0
- Memory mux:
  - The granted port drives `mem_a` and `mem_wd`.
  - `mem_we` = granted port's `we`.
  - With no grant: `mem_a`=`cpu_adr`, `mem_wd`=`cpu_wd`, `mem_we`=0.
- Read (granted with `we`=0): `mem_rd` is captured into that port's `rdata` at the grant edge, and `rvalid`=1 for the following cycle.
- Write (granted with `we`=1): memory commits at the grant edge. `rvalid` stays 0 and `rdata` holds its old value.
- A port may be granted every cycle (back-to-back). The requester deasserts `req`, or presents the next access, after sampling `gnt`=1.
- `owner` encoding: NONE / CPU / DBG.
- Registered state: `wait_cnt`, `cpu_rvalid`, `dbg_rvalid`, `cpu_rdata`, `dbg_rdata`.

## Timing
- Reset (`reset`=0, asynchronous):
  - `wait_cnt`=0, both `rvalid`=0, both `rdata`=0
  - `cpu_gnt`=`dbg_gnt`=0 and `mem_we`=0, forced combinationally while reset is asserted
  - `owner`=NONE
- Grant latency: 0 cycles when the port wins. Read-data latency: 1 cycle after the grant edge.
- Worst-case debug wait: `DBG_MAX_WAIT` cycles under continuous `cpu_req`. The core then loses exactly one cycle.
- Simultaneous requests with `wait_cnt`<`DBG_MAX_WAIT`: the core is granted and `wait_cnt`+1.
- `DBG_MAX_WAIT`=0: debug has strict priority.
- Reset mid-access: a pending `rvalid` is discarded and the grant drops immediately. No write occurs at any edge where `reset`=0.
- Deasserting `dbg_req` before it is granted clears `wait_cnt`, with no penalty to the core.

## Configuration
- `MEM_ARB_DBG_WRITE_EN` defined: `dbg_we` is honored, so the debug port can load memory.
- Not defined: debug writes are granted and complete the handshake, but `mem_we` is forced to 0 for debug-owned cycles. Debug reads are unaffected. This build is read-only for synthesis on the board.

## Structure
- Package `mem_arb_pkg` holds:
  - owner encoding `OWN_NONE`=2'b00, `OWN_CPU`=2'b01, `OWN_DBG`=2'b10
  - default `AW`/`DW` constants
- Sub-module `mem_arb_wait_ctr` is the saturating starvation counter.
  - Inputs: `clk`, `reset`, `inc`, `clr`.
  - Output: `at_max`.
  - Width: `$clog2(DBG_MAX_WAIT+1)`, minimum 1.
- Grant logic, mux and read-return registers stay in `mem_arbiter`.

## Test plan
- Core read only: `cpu_req`=1, `cpu_adr`=0x10, memory word 0xE3A00005. Required: `cpu_gnt`=1 the same cycle, and `cpu_rdata`=0xE3A00005 with `cpu_rvalid`=1 the next cycle.
- Starvation with `DBG_MAX_WAIT`=4: `cpu_req` and `dbg_req` held high. Required: 4 core grants, then `dbg_gnt`=1 on cycle 5, then the core resumes and `wait_cnt` returns to 0.
- Debug write with the macro defined: `dbg_we`=1, `dbg_adr`=0x40, `dbg_wd`=0xDEADBEEF, then a core read of 0x40. Required: 0xDEADBEEF. Without the macro, the read returns the prior value.
- Back-to-back core reads of 0x00, 0x04 and 0x08. Required: three consecutive grants and three consecutive `rvalid` cycles with the matching words.
- `reset` driven to 0 in the cycle after a core read grant. Required: `cpu_rvalid`=0, `cpu_rdata`=0, and `mem_we`=0 immediately.
- `DBG_MAX_WAIT`=0 with both requesting. Required: `dbg_gnt`=1 and `cpu_gnt`=0 every cycle `dbg_req` is high.
